// File: rtl/mult_pkg.sv
// mult_arbiter shared types and constants.
// State encoding and default widths for the shared-multiplier front end.
package mult_pkg;

  localparam int MULT_W = 32;
  localparam int PROD_W = 2 * MULT_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker for mult_arbiter.
// Search begins at i_ptr and wraps modulo NREQ; caller owns the pointer.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 3
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [IDW-1:0]  o_idx,
  output logic            o_any
);

  logic [2*NREQ-1:0] w_dbl;
  logic [2*NREQ-1:0] w_sh;
  logic [IDW:0]      w_off;
  logic [IDW:0]      w_sum;

  assign w_dbl = {i_req, i_req};
  assign w_sh  = w_dbl >> i_ptr;

  // Rotate so the pointer is bit 0, take the lowest set bit, unrotate.
  always_comb begin
    o_any = 1'b0;
    w_off = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!o_any && w_sh[k]) begin
        o_any = 1'b1;
        w_off = (IDW+1)'(k);
      end
    end
    w_sum = {1'b0, i_ptr} + w_off;
    if (w_sum >= (IDW+1)'(NREQ)) begin
      w_sum = w_sum - (IDW+1)'(NREQ);
    end
    o_idx = w_sum[IDW-1:0];
    o_gnt = '0;
    if (o_any) begin
      o_gnt[o_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin front end sharing one sequential multiplier among NREQ clients.
// Optional MULT_ARB_ZERO_BYPASS_EN: zero operands skip the multiplier.
module mult_arbiter
  import mult_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = MULT_W,
  parameter int IDW   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_mcand,
  input  logic [NREQ*WIDTH-1:0] req_mlier,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [2*WIDTH-1:0]    rsp_product,
  output logic                  mul_start,
  output logic [WIDTH-1:0]      mul_mcand,
  output logic [WIDTH-1:0]      mul_mlier,
  input  logic                  mul_done,
  input  logic [2*WIDTH-1:0]    mul_product
);

  state_t             r_state;
  state_t             w_next;
  logic [IDW-1:0]     r_ptr;
  logic [IDW-1:0]     r_id;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mlier;
  logic [2*WIDTH-1:0] r_product;

  logic [NREQ-1:0]    w_gnt;
  logic [IDW-1:0]     w_idx;
  logic               w_any;
  logic [WIDTH-1:0]   w_mcand;
  logic [WIDTH-1:0]   w_mlier;
  logic               w_zero;
  logic               w_accept;
  logic [IDW-1:0]     w_ptr_nxt;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr (
    .i_req (req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign w_mcand  = req_mcand[w_idx*WIDTH +: WIDTH];
  assign w_mlier  = req_mlier[w_idx*WIDTH +: WIDTH];
  assign w_accept = (r_state == IDLE) && w_any && rst;

  assign w_ptr_nxt = (w_idx == IDW'(NREQ-1)) ? '0 : w_idx + 1'b1;

`ifdef MULT_ARB_ZERO_BYPASS_EN
  assign w_zero = (w_mcand == '0) || (w_mlier == '0);
`else
  assign w_zero = 1'b0;
`endif

  // Next-state and handshake outputs.
  always_comb begin
    w_next    = r_state;
    req_ready = '0;
    mul_start = 1'b0;
    rsp_valid = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (rst) begin
          req_ready = w_gnt;
        end
        if (w_any) begin
          w_next = w_zero ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        mul_start = 1'b1;
        w_next    = WAIT;
      end
      WAIT: begin
        if (mul_done) begin
          w_next = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // State register; reset drops any in-flight operation.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Grant pointer, latched operands, id and product.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ptr     <= '0;
      r_id      <= '0;
      r_mcand   <= '0;
      r_mlier   <= '0;
      r_product <= '0;
    end else begin
      if (w_accept) begin
        r_ptr   <= w_ptr_nxt;
        r_id    <= w_idx;
        r_mcand <= w_mcand;
        r_mlier <= w_mlier;
        if (w_zero) begin
          r_product <= '0;
        end
      end
      if (r_state == WAIT && mul_done) begin
        r_product <= mul_product;
      end
    end
  end

  assign rsp_id      = r_id;
  assign rsp_product = r_product;
  assign mul_mcand   = r_mcand;
  assign mul_mlier   = r_mlier;

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: directed timing cases plus randomized traffic
// checked against a transaction-level round-robin/product model.
module tb_mult_arbiter;

  localparam int N   = 4;
  localparam int W   = 32;
  localparam int LAT = 6;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_mcand = '0;
  logic [N*W-1:0] req_mlier = '0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [2:0]     rsp_id;
  logic [2*W-1:0] rsp_product;
  logic           mul_start;
  logic [W-1:0]   mul_mcand;
  logic [W-1:0]   mul_mlier;
  logic           mul_done = 1'b0;
  logic [2*W-1:0] mul_product = '0;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int mp     = 0;

  mult_arbiter #(.NREQ(N), .WIDTH(W), .IDW(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_mcand   (req_mcand),
    .req_mlier   (req_mlier),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_product (rsp_product),
    .mul_start   (mul_start),
    .mul_mcand   (mul_mcand),
    .mul_mlier   (mul_mlier),
    .mul_done    (mul_done),
    .mul_product (mul_product)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Fixed-latency multiplier: start seen in cycle c -> done in c+LAT.
  int             done_cyc = -100;
  logic [2*W-1:0] pend = '0;
  always @(negedge clk) begin
    mul_done = (cyc == done_cyc);
    if (mul_done) mul_product = pend;
    if (mul_start) begin
      done_cyc = cyc + LAT;
      pend = 64'(mul_mcand) * 64'(mul_mlier);
    end
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (p + k) % N;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] rnd_op();
    int s;
    s = $urandom_range(0, 7);
    if (s == 0) return '0;
    if (s == 1) return '1;
    return W'($urandom);
  endfunction

  task automatic set_req(input int id, input logic [W-1:0] a,
                         input logic [W-1:0] b);
    req_mcand[id*W +: W] = a;
    req_mlier[id*W +: W] = b;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    mp = 0;
  endtask

  // One request from the masked set; returns timing relative to cycles.
  task automatic single(input logic [N-1:0] mask, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic rr,
                        output int t_acc, output int t_st,
                        output int t_rsp, output int n_st,
                        output int g);
    int e;
    t_acc = -1; t_st = -1; t_rsp = -1; n_st = 0; g = -1;
    e = rr_pick(mask, mp);
    @(negedge clk);
    for (int i = 0; i < N; i++) if (mask[i]) set_req(i, a, b);
    req_valid = mask;
    rsp_ready = rr;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (t_acc < 0 && req_ready != '0) begin
        t_acc = cyc;
        for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
        check("grant", 64'(g), 64'(e));
        mp = (e + 1) % N;
      end
      if (mul_start) begin
        n_st++;
        if (t_st < 0) t_st = cyc;
      end
      if (rsp_valid) begin
        t_rsp = cyc;
        break;
      end
      @(negedge clk);
      if (t_acc >= 0) req_valid = '0;
    end
    req_valid = '0;
    if (t_rsp < 0) check("single_timeout", 0, 1);
  endtask

  // Random or saturated traffic against a transaction-level model.
  task automatic stream(input int n, input bit allv);
    int             q_id[$];
    logic [63:0]    q_p[$];
    bit             busy;
    bit             free_nxt;
    int             ng;
    int             c;
    int             e;
    int             g;
    logic [N-1:0]   er;
    busy = 0; free_nxt = 0; ng = 0; c = 0;
    while (1) begin
      @(negedge clk);
      if (free_nxt) begin
        busy = 0;
        free_nxt = 0;
      end
      if (c >= n && !busy) break;
      if (c >= n + 80) begin
        check("stream_timeout", 0, 1);
        break;
      end
      if (c < n) begin
        req_valid = allv ? '1 : N'($urandom);
        for (int i = 0; i < N; i++) set_req(i, rnd_op(), rnd_op());
      end else begin
        req_valid = '0;
      end
      rsp_ready = allv ? 1'b1 : ($urandom_range(0, 3) != 0);
      #1;
      e  = busy ? -1 : rr_pick(req_valid, mp);
      er = '0;
      if (e >= 0) er[e] = 1'b1;
      check("req_ready", 64'(req_ready), 64'(er));
      if (allv && req_ready != '0) begin
        g = -1;
        for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
        check("rr_order", 64'(g), 64'(ng % N));
        ng++;
      end
      if (e >= 0) begin
        q_id.push_back(e);
        q_p.push_back(64'(req_mcand[e*W +: W]) * 64'(req_mlier[e*W +: W]));
        busy = 1;
        mp = (e + 1) % N;
      end
      if (rsp_valid && rsp_ready) begin
        if (q_id.size() == 0) begin
          check("rsp_unexpected", 1, 0);
        end else begin
          check("rsp_id", 64'(rsp_id), 64'(q_id.pop_front()));
          check("rsp_product", rsp_product, q_p.pop_front());
        end
        free_nxt = 1;
      end
      c++;
    end
    req_valid = '0;
    check("stream_drain", 64'(q_id.size()), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ta, ts, tr, ns, g;
    logic [63:0] p0;

    // Reset state
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_req_ready", 64'(req_ready), 0);
    check("rst_rsp_valid", 64'(rsp_valid), 0);
    check("rst_mul_start", 64'(mul_start), 0);
    check("rst_rsp_id", 64'(rsp_id), 0);
    check("rst_rsp_product", rsp_product, 0);
    check("rst_mcand", 64'(mul_mcand), 0);
    check("rst_mlier", 64'(mul_mlier), 0);
    rst = 1'b1;
    mp = 0;

    // Single request 2: 7*9
    single(4'b0100, 32'd7, 32'd9, 1'b1, ta, ts, tr, ns, g);
    check("t1_start_lat", 64'(ts - ta), 1);
    check("t1_rsp_lat", 64'(tr - ta), 8);
    check("t1_id", 64'(rsp_id), 2);
    check("t1_product", rsp_product, 64'd63);
    check("t1_nstart", 64'(ns), 1);
    @(negedge clk);
    #1;
    check("t1_rsp_drop", 64'(rsp_valid), 0);

    // Response back-pressure for 10 cycles
    single(4'b0001, 32'd1234, 32'd5678, 1'b0, ta, ts, tr, ns, g);
    p0 = rsp_product;
    check("t3_product", p0, 64'd1234 * 64'd5678);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      req_valid = '1;
      #1;
      check("t3_valid", 64'(rsp_valid), 1);
      check("t3_stable", rsp_product, p0);
      check("t3_no_ready", 64'(req_ready), 0);
      check("t3_no_start", 64'(mul_start), 0);
    end
    @(negedge clk);
    req_valid = '0;
    rsp_ready = 1'b1;
    #1;
    check("t3_id", 64'(rsp_id), 0);

    // Reset during WAIT; late mul_done must be ignored
    @(negedge clk);
    req_valid = 4'b1000;
    set_req(3, 32'd100, 32'd200);
    #1;
    check("t4_grant", 64'(req_ready), 64'(4'b1000));
    @(negedge clk);
    req_valid = '0;
    #1;
    check("t4_start", 64'(mul_start), 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("t4_rsp_valid", 64'(rsp_valid), 0);
    check("t4_mul_start", 64'(mul_start), 0);
    check("t4_req_ready", 64'(req_ready), 0);
    check("t4_rsp_id", 64'(rsp_id), 0);
    check("t4_rsp_product", rsp_product, 0);
    check("t4_mcand", 64'(mul_mcand), 0);
    check("t4_mlier", 64'(mul_mlier), 0);
    rst = 1'b1;
    mp = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      check("t4_quiet", 64'({rsp_valid, mul_start}), 0);
    end
    single(4'b1111, 32'd3, 32'd11, 1'b1, ta, ts, tr, ns, g);
    check("t4_id", 64'(rsp_id), 0);
    check("t4_product", rsp_product, 64'd33);

    // Full-scale operands
    single(4'b0010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, ta, ts, tr, ns, g);
    check("t5_product", rsp_product, 64'hFFFF_FFFE_0000_0001);
    check("t5_id", 64'(rsp_id), 1);

    // Zero operand
    single(4'b0010, 32'd0, 32'd5, 1'b1, ta, ts, tr, ns, g);
    check("t6_product", rsp_product, 0);
    check("t6_id", 64'(rsp_id), 1);
`ifdef MULT_ARB_ZERO_BYPASS_EN
    check("t6_rsp_lat", 64'(tr - ta), 1);
    check("t6_nstart", 64'(ns), 0);
`else
    check("t6_start_lat", 64'(ts - ta), 1);
    check("t6_rsp_lat", 64'(tr - ta), 8);
`endif

    // Saturated round-robin, then random traffic
    do_reset();
    stream(60, 1'b1);
    stream(400, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
